// File: rtl/zmem_pkg.sv
// Shared types and defaults for the Z80 memory-access stall responder.
package zmem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } zstate_e;

    localparam int unsigned TIMEOUT_DEF   = 63;
    localparam logic [7:0]  IDLE_DATA_DEF = 8'hFF;
endpackage

// File: rtl/zmem_stall.sv
// Turns a Z80 memory cycle into one arbiter request and stalls the CPU clock
// until the arbiter acknowledges or the wait budget runs out.
module zmem_stall
    import zmem_pkg::*;
#(
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter logic [7:0]  IDLE_DATA = IDLE_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        zpos,
    input  logic        zneg,
    input  logic        mreq_s,
    input  logic        rd_s,
    input  logic        wr_s,
    input  logic        rfsh_s,
    input  logic [15:0] a,
    input  logic [7:0]  dout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  din,
    output logic        cpu_stall,
    output logic        timeout_err
);
    localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    zstate_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          edge_q, edge_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    din_q, din_d;
    logic          terr_q, terr_d;
    logic          acc, start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            din_q   <= IDLE_DATA;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            din_q   <= din_d;
            terr_q  <= terr_d;
        end
    end

    // A bus edge must have been seen since IDLE was entered, so a held access
    // cannot start a second request inside the same Z80 bus cycle.
    assign acc   = mreq_s & (rd_s | wr_s) & ~rfsh_s;
    assign start = acc & (state_q == IDLE) & (edge_q | zpos | zneg);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        din_d   = din_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (zpos | zneg) edge_d = 1'b1;
                if (start) begin
                    state_d = REQ;
                    edge_d  = 1'b0;
                    addr_d  = a;
                    we_d    = wr_s;
                    wdata_d = dout;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (!we_q) din_d = mem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    if (!we_q) din_d = IDLE_DATA;
                    terr_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (!acc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall is combinational on start so the clock generator sees it in the
    // very cycle the access begins; gated so reset forces it low.
    assign cpu_stall   = rst_n & (start | (state_q == REQ));
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign din         = din_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_zmem_stall.sv
// Randomized transaction-level check of zmem_stall against outcome rules.
module tb_zmem_stall;
    localparam int TMO = 63;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        zpos, zneg, mreq_s, rd_s, wr_s, rfsh_s;
    logic [15:0] a;
    logic [7:0]  dout;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  din;
    logic        cpu_stall, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: last value the CPU should read, and whether a bus edge
    // is pending that can qualify the next access.
    logic [7:0] m_din;
    bit         m_armed;

    zmem_stall dut (
        .clk(clk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg),
        .mreq_s(mreq_s), .rd_s(rd_s), .wr_s(wr_s), .rfsh_s(rfsh_s),
        .a(a), .dout(dout), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .din(din), .cpu_stall(cpu_stall),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        mreq_s = 0; rd_s = 0; wr_s = 0; rfsh_s = 0;
        zpos = 0; zneg = 0; mem_ack = 0;
    endtask

    // kind: 0 read, 1 write, 2 refresh, 3 read with no fresh bus edge.
    // d: REQ cycles before ack (beyond TMO means never). hold: extra cycles
    // the access stays asserted after the request finishes.
    task automatic run_txn(input int kind, input int d, input int hold);
        logic [15:0] ea;
        logic [7:0]  ed, erd;
        bit exp_start, acc_on, done, latch_ok, fin, prev_req, seen_req;
        int stall_n, rises, pulses, rq, acc_cnt, hold_left, after, exp_stall;
        ea = 16'($urandom); ed = 8'($urandom); erd = 8'($urandom);
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        if (kind != 3) begin
            zneg = 1; m_armed = 1;
            @(posedge clk); #1;
            zneg = 0;
        end
        exp_start = (kind != 2) && m_armed;
        a = ea; dout = ed; mreq_s = 1;
        rd_s = (kind != 1); wr_s = (kind == 1); rfsh_s = (kind == 2);
        acc_on = 1; done = 0; latch_ok = 1; fin = 0; prev_req = 0; seen_req = 0;
        stall_n = 0; rises = 0; pulses = 0; rq = 0; acc_cnt = 0; after = 0;
        hold_left = hold;
        for (int c = 0; c < 300 && !fin; c++) begin
            mem_ack = 0;
            if (mem_req === 1'b1) begin
                if (rq == d) begin
                    mem_ack = 1; mem_rdata = erd;
                end else if ($urandom_range(1) == 1) begin
                    a = 16'($urandom); dout = 8'($urandom);
                end
                rq++;
            end else if ($urandom_range(3) == 0) begin
                mem_ack = 1; mem_rdata = 8'($urandom);
            end
            #1;
            if (cpu_stall === 1'b1) stall_n++;
            if (mem_req === 1'b1 && !prev_req) rises++;
            if (mem_req === 1'b1) begin
                seen_req = 1;
                if (mem_addr !== ea || mem_we !== (kind == 1) ||
                    (kind == 1 && mem_wdata !== ed)) latch_ok = 0;
            end
            if (timeout_err === 1'b1) pulses++;
            if (prev_req && mem_req === 1'b0) done = 1;
            prev_req = (mem_req === 1'b1);
            @(posedge clk); #1;
            if (acc_on) begin
                acc_cnt++;
                if (exp_start ? done : (acc_cnt >= 3)) begin
                    if (hold_left == 0) begin
                        acc_on = 0;
                        mreq_s = 0; rd_s = 0; wr_s = 0; rfsh_s = 0; zpos = 0;
                    end else hold_left--;
                end
                if (acc_on && seen_req) zpos = 1'($urandom_range(1));
            end else begin
                after++;
                if (after == 3) fin = 1;
            end
        end
        mem_ack = 0;
        chk("txn_bound", 32'(fin), 32'd1);
        exp_stall = exp_start ? ((d > TMO ? TMO : d) + 2) : 0;
        chk("stall_cycles", 32'(stall_n), 32'(exp_stall));
        chk("req_pulses", 32'(rises), exp_start ? 32'd1 : 32'd0);
        chk("timeout_pulses", 32'(pulses), (exp_start && d > TMO) ? 32'd1 : 32'd0);
        chk("latched_bus", 32'(latch_ok), 32'd1);
        if (exp_start) begin
            m_armed = 0;
            if (kind != 1) m_din = (d > TMO) ? 8'hFF : erd;
        end
        chk("din", 32'(din), 32'(m_din));
    endtask

    initial begin
        int kind, d, pick;
        bus_idle();
        a = '0; dout = '0; mem_rdata = '0;
        rst_n = 0;
        mreq_s = 1; rd_s = 1; zpos = 1;
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_din", 32'(din), 32'hFF);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        bus_idle();
        @(posedge clk); #1;
        rst_n = 1;
        m_din = 8'hFF; m_armed = 0;

        run_txn(0, 3, 2);
        run_txn(1, 0, 2);
        run_txn(0, 100, 1);
        run_txn(2, 0, 0);
        run_txn(0, 1, 20);
        run_txn(3, 0, 1);
        run_txn(0, 63, 0);
        run_txn(1, 64, 0);
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(3);
            pick = $urandom_range(9);
            d = (pick < 6) ? pick : (pick == 6) ? 10 : (pick == 7) ? 62 :
                (pick == 8) ? 63 : 80;
            run_txn(kind, d, $urandom_range(6));
        end

        // Reset while a request is outstanding.
        bus_idle();
        repeat (2) @(posedge clk);
        #1; zneg = 1;
        @(posedge clk); #1; zneg = 0;
        a = 16'h1234; mreq_s = 1; rd_s = 1;
        for (int c = 0; c < 5 && mem_req !== 1'b1; c++) begin
            @(posedge clk); #1;
        end
        chk("rr_req_up", 32'(mem_req), 32'd1);
        rst_n = 0; zpos = 1;
        #1;
        chk("rr_mem_req", 32'(mem_req), 32'd0);
        chk("rr_stall", 32'(cpu_stall), 32'd0);
        chk("rr_din", 32'(din), 32'hFF);
        chk("rr_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        bus_idle();
        rst_n = 1;
        mem_ack = 1; mem_rdata = 8'h3C;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rr_late_ack_req", 32'(mem_req), 32'd0);
            chk("rr_late_ack_din", 32'(din), 32'hFF);
        end
        mem_ack = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/zmem_stall.md
Name: zmem_stall

Overview:
Memory-access responder for the Z80 clock generator. It detects Z80 memory cycles, issues a request to the DRAM arbiter, and holds cpu_stall high until the arbiter acknowledges. The clock generator therefore suppresses zpos/zneg edges until data is valid. It sits between the synchronized Z80 bus signals and the arbiter, and returns latched read data to the CPU data mux.

Parameters:
TIMEOUT, 63, max clk cycles waiting for ack before forced release (6-bit counter width derived from it)
IDLE_DATA, 8'hFF, read data returned on reset and on timeout

Ports:
clk  in  1  28 MHz system clock
rst_n  in  1  asynchronous active-low reset
zpos  in  1  Z80 positive-edge strobe from clock generator
zneg  in  1  Z80 negative-edge strobe from clock generator
mreq_s  in  1  synchronized MREQ, active high
rd_s  in  1  synchronized RD, active high
wr_s  in  1  synchronized WR, active high
rfsh_s  in  1  synchronized RFSH, active high (refresh cycles are ignored)
a  in  16  Z80 address
dout  in  8  Z80 write data
mem_req  out  1  request to arbiter
mem_we  out  1  1 = write request
mem_addr  out  16  latched address
mem_wdata  out  8  latched write data
mem_ack  in  1  arbiter acknowledge; rdata valid in the same cycle
mem_rdata  in  8  arbiter read data
din  out  8  latched read data to CPU
cpu_stall  out  1  stall to clock generator
timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, din=IDLE_DATA, timeout_err=0, state=IDLE, counter=0. cpu_stall=0 while in reset.
- acc = mreq_s & (rd_s|wr_s) & !rfsh_s. start = acc & state==IDLE. zpos/zneg only qualify the edge: start is honoured in a cycle where zpos|zneg was seen since the last IDLE entry. A sticky flag records this and is cleared on leaving IDLE.
- cpu_stall = start | (state==REQ). start is a combinational term, so stall is visible in the same cycle the access begins. This is required because the clock generator registers zpos/zneg using stall.
- FSM:
  - IDLE: on start, latch a→mem_addr, wr_s→mem_we, dout→mem_wdata; set mem_req=1; counter=0; go to REQ.
  - REQ: mem_req=1.
    - On mem_ack: if !mem_we, latch mem_rdata into din. Drop mem_req next cycle. Go to DONE.
    - Otherwise, if counter==TIMEOUT: if read, din=IDLE_DATA; pulse timeout_err; mem_req=0; go to DONE.
    - Otherwise counter+1, saturating.
  - DONE: stall low. Wait for acc==0, then go to IDLE. This prevents retrigger within one bus cycle.
- mem_ack in IDLE or DONE is ignored. mem_ack in the same cycle as start is ignored; only REQ samples ack.
- Minimum stall: 2 cycles (start cycle plus the ack cycle when ack arrives on the first REQ cycle).
- mem_addr, mem_we and mem_wdata are stable from the cycle after start until leaving REQ.
- Mid-access changes of turbo, a or dout have no effect; the access completes with the latched values.
- acc dropping while in REQ (aborted cycle): the request still completes or times out, then goes to DONE and then to IDLE.
- Reset mid-operation: all outputs return immediately to reset values and any pending ack is discarded.

Decomposition:
- Package zmem_pkg holds: state enum (IDLE, REQ, DONE; 2-bit encoding), TIMEOUT default, IDLE_DATA default.
- No sub-module is needed; the counter and FSM stay in one module.

Test Plan:
1. Read: a=16'h8000, mreq_s+rd_s after zneg; ack 3 cycles later with rdata=8'h5A. Expect: cpu_stall high from the start cycle through the ack cycle (5 cycles); mem_addr=8000, mem_we=0; din=5A one cycle after ack.
2. Write: a=16'h4001, dout=8'hC3, wr_s; immediate ack. Expect: mem_we=1, mem_wdata=C3, stall high for 2 cycles; din unchanged.
3. Timeout: read with no ack. Expect: stall high for TIMEOUT+2 cycles; timeout_err single pulse; din=FF; mem_req drops.
4. Refresh: mreq_s+rd_s with rfsh_s=1. Expect: no mem_req, cpu_stall stays 0.
5. Retrigger guard: hold acc high for 20 cycles after ack. Expect: exactly one mem_req pulse; a new request only after acc falls and rises again.
6. Reset mid-REQ: assert rst_n=0 while mem_req=1. Expect: mem_req=0 and cpu_stall=0 immediately; din=FF. A later ack is ignored.
